// File: rtl/spi_master_tx_pkg.sv
// Shared SPI definitions for spi_master_tx and the matching SPI receiver.
// Covers word width, bit order, transmitter states and divider counter sizing.
package spi_pkg;

    localparam int unsigned SPI_WORD_W    = 8;
    localparam bit          SPI_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } spi_tx_state_e;

    // Divider counter width: clog2(div), never narrower than one bit
    function automatic int unsigned cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Byte handshake and SPI pin bundle for spi_master_tx.
// The master modport is the transmitter's view; slave is the user/pin side.
interface spi_master_tx_if;
    import spi_pkg::*;

    logic [SPI_WORD_W-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [SPI_WORD_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  spi_clk;
    logic                  spi_mosi;
    logic                  spi_miso;

    modport master (
        input  tx_data, tx_valid, spi_miso,
        output tx_ready, rx_data, rx_valid, busy, spi_clk, spi_mosi
    );

    modport slave (
        output tx_data, tx_valid, spi_miso,
        input  tx_ready, rx_data, rx_valid, busy, spi_clk, spi_mosi
    );

endinterface

// File: rtl/spi_master_tx_phase_timer.sv
// Counts CLK_DIV clk_sys cycles per spi_clk half-period while enabled.
// phase_end pulses on the last cycle of each half-period.
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic enable,
    output logic phase_end
);

    localparam int unsigned CNT_W = cnt_width(CLK_DIV);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("spi_phase_timer: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] div_cnt;

    assign phase_end = enable && (div_cnt == CNT_W'(CLK_DIV - 1));

    // Held at zero while idle so every phase starts from a clean count
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!enable || phase_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts each accepted byte out on spi_mosi and captures
// spi_miso on every rising spi_clk edge, exactly 8 full clock periods per byte.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic     clk_sys,
    input  logic     rst,
    spi_master_tx_if.master bus
);

    localparam int unsigned W = SPI_WORD_W;

    spi_tx_state_e  state_q, state_d;
    logic [W-1:0]   tx_sh, rx_sh, rx_data_q;
    logic [W-1:0]   tx_next, rx_next;
    logic [2:0]     bit_cnt;
    logic           spi_clk_q, spi_mosi_q, rx_valid_q;
    logic           phase_end;
    logic           accept, rise, fall_next, fall_last;

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .enable    (state_q != IDLE),
        .phase_end (phase_end)
    );

    assign tx_next = SPI_MSB_FIRST ? {tx_sh[W-2:0], 1'b0} : {1'b0, tx_sh[W-1:1]};
    assign rx_next = SPI_MSB_FIRST ? {rx_sh[W-2:0], bus.spi_miso}
                                   : {bus.spi_miso, rx_sh[W-1:1]};

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        rise         = 1'b0;
        fall_next    = 1'b0;
        fall_last    = 1'b0;
        bus.tx_ready = (state_q == IDLE);
        bus.busy     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    accept  = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    rise    = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    if (bit_cnt == 3'(W - 1)) begin
                        fall_last = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        fall_next = 1'b1;
                        state_d   = LOW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_data_q  <= '0;
            bit_cnt    <= '0;
            spi_clk_q  <= 1'b0;
            spi_mosi_q <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                tx_sh      <= bus.tx_data;
                spi_mosi_q <= SPI_MSB_FIRST ? bus.tx_data[W-1] : bus.tx_data[0];
                bit_cnt    <= '0;
            end
            if (rise) begin
                spi_clk_q <= 1'b1;
                rx_sh     <= rx_next;
            end
            if (fall_next) begin
                spi_clk_q  <= 1'b0;
                bit_cnt    <= bit_cnt + 3'd1;
                tx_sh      <= tx_next;
                spi_mosi_q <= SPI_MSB_FIRST ? tx_next[W-1] : tx_next[0];
            end
            if (fall_last) begin
                spi_clk_q  <= 1'b0;
                rx_data_q  <= rx_sh;
                rx_valid_q <= 1'b1;
            end
        end
    end

    assign bus.spi_clk  = spi_clk_q;
    assign bus.spi_mosi = spi_mosi_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: CLK_DIV=2 instance (loopback or responder on
// spi_miso) and CLK_DIV=1 instance (loopback), with a mode-0 receiver model.
module tb_spi_master_tx;
    import spi_pkg::*;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    spi_master_tx_if a_if();
    spi_master_tx_if b_if();

    spi_master_tx #(.CLK_DIV(2)) u_a (.clk_sys(clk_sys), .rst(rst), .bus(a_if.master));
    spi_master_tx #(.CLK_DIV(1)) u_b (.clk_sys(clk_sys), .rst(rst), .bus(b_if.master));

    int checks = 0;
    int errors = 0;

    // Responder: presents resp_byte MSB first, advancing on spi_clk falling edges
    logic       miso_sel;
    logic [7:0] resp_byte;
    int unsigned fall_bits;
    always @(negedge a_if.spi_clk or posedge rst) begin
        if (rst) fall_bits = 0;
        else     fall_bits = (fall_bits == 7) ? 0 : fall_bits + 1;
    end
    assign a_if.spi_miso = miso_sel ? resp_byte[3'(7 - fall_bits)] : a_if.spi_mosi;
    assign b_if.spi_miso = b_if.spi_mosi;

    // Receiver model: samples spi_mosi on each rising spi_clk edge
    int unsigned bits;
    logic [7:0]  rx_m;
    logic [7:0]  got_q[$];
    time         rise_t[$];
    time         b_rise_t[$];
    always @(posedge a_if.spi_clk or posedge rst) begin
        if (rst) begin
            bits = 0;
        end else begin
            rx_m = {rx_m[6:0], a_if.spi_mosi};
            rise_t.push_back($time);
            if (bits == 7) begin
                got_q.push_back(rx_m);
                bits = 0;
            end else begin
                bits = bits + 1;
            end
        end
    end
    always @(posedge b_if.spi_clk) b_rise_t.push_back($time);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] d, output time t_acc);
        @(negedge clk_sys);
        if (sel) begin b_if.tx_data = d; b_if.tx_valid = 1'b1; end
        else     begin a_if.tx_data = d; a_if.tx_valid = 1'b1; end
        @(posedge clk_sys);
        t_acc = $time;
        @(negedge clk_sys);
        if (sel) b_if.tx_valid = 1'b0;
        else     a_if.tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input bit sel, output time t);
        bit seen;
        seen = 1'b0;
        t    = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_sys);
            if ((sel ? b_if.rx_valid : a_if.rx_valid) === 1'b1) begin
                seen = 1'b1;
                t    = $time;
            end
        end
        if (!seen) check("rx_valid_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] cyc(input time from_t, input time to_t);
        return 32'((to_t - from_t) / 10);
    endfunction

    initial begin
        time ta, tr, tr2;
        int  base, gbase;
        bit  reached;

        a_if.tx_data = '0; a_if.tx_valid = 1'b0;
        b_if.tx_data = '0; b_if.tx_valid = 1'b0;
        miso_sel = 1'b0; resp_byte = '0;
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        check("rst_spi_clk",  a_if.spi_clk,  0);
        check("rst_mosi",     a_if.spi_mosi, 0);
        check("rst_ready",    a_if.tx_ready, 1);
        check("rst_busy",     a_if.busy,     0);
        check("rst_rx_valid", a_if.rx_valid, 0);
        check("rst_rx_data",  a_if.rx_data,  0);

        // Loopback 0xA5: rising edges at 2,6,...,30; rx_valid at 32
        base = rise_t.size(); gbase = got_q.size();
        send(1'b0, 8'hA5, ta);
        wait_rx(1'b0, tr);
        check("a5_rxv_cycle", cyc(ta + 5, tr), 32);
        check("a5_rx_data", a_if.rx_data, 8'hA5);
        check("a5_ready_in_rxv", a_if.tx_ready, 1);
        check("a5_rises", rise_t.size() - base, 8);
        for (int k = 1; k <= 8; k++)
            if (rise_t.size() >= base + k)
                check($sformatf("a5_rise%0d_cycle", k), cyc(ta, rise_t[base+k-1]), (2*k-1)*2);
        check("a5_model_byte", (got_q.size() > gbase) ? got_q[gbase] : 8'hxx, 8'hA5);
        @(negedge clk_sys);
        check("a5_rxv_width", a_if.rx_valid, 0);

        // Responder drives 0x3C while 0x00 is sent
        miso_sel = 1'b1; resp_byte = 8'h3C;
        gbase = got_q.size();
        send(1'b0, 8'h00, ta);
        wait_rx(1'b0, tr);
        check("resp_rx_data", a_if.rx_data, 8'h3C);
        check("resp_mosi_byte", (got_q.size() > gbase) ? got_q[gbase] : 8'hxx, 8'h00);
        miso_sel = 1'b0;

        // Back-to-back: tx_valid held, 0x01 then 0x80
        base = rise_t.size(); gbase = got_q.size();
        @(negedge clk_sys);
        a_if.tx_data = 8'h01; a_if.tx_valid = 1'b1;
        @(posedge clk_sys);
        ta = $time;
        @(negedge clk_sys);
        a_if.tx_data = 8'h80;
        wait_rx(1'b0, tr);
        check("b2b_first_data", a_if.rx_data, 8'h01);
        check("b2b_ready_in_rxv", a_if.tx_ready, 1);
        @(negedge clk_sys);
        a_if.tx_valid = 1'b0;
        check("b2b_second_busy", a_if.busy, 1);
        wait_rx(1'b0, tr2);
        check("b2b_second_data", a_if.rx_data, 8'h80);
        check("b2b_period", cyc(tr, tr2), 33);
        repeat (4) @(negedge clk_sys);
        check("b2b_rises", rise_t.size() - base, 16);
        check("b2b_model_0", (got_q.size() > gbase) ? got_q[gbase] : 8'hxx, 8'h01);
        check("b2b_model_1", (got_q.size() > gbase + 1) ? got_q[gbase+1] : 8'hxx, 8'h80);

        // Inputs wiggled mid-transfer are ignored
        base = rise_t.size(); gbase = got_q.size();
        send(1'b0, 8'hC3, ta);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            a_if.tx_valid = ~a_if.tx_valid;
            a_if.tx_data  = ~a_if.tx_data;
        end
        wait_rx(1'b0, tr);
        check("ign_rx_data", a_if.rx_data, 8'hC3);
        repeat (3) @(negedge clk_sys);
        check("ign_no_accept", a_if.busy, 0);
        check("ign_rises", rise_t.size() - base, 8);
        check("ign_model", (got_q.size() > gbase) ? got_q[gbase] : 8'hxx, 8'hC3);

        // Asynchronous reset after the 3rd rising edge
        base = rise_t.size();
        send(1'b0, 8'h77, ta);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (rise_t.size() - base >= 3) reached = 1'b1;
            else @(negedge clk_sys);
        end
        check("rst_mid_reached", reached, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_spi_clk",  a_if.spi_clk,  0);
        check("rst_mid_busy",     a_if.busy,     0);
        check("rst_mid_ready",    a_if.tx_ready, 1);
        check("rst_mid_rx_valid", a_if.rx_valid, 0);
        @(negedge clk_sys);
        rst = 1'b0;
        gbase = got_q.size();
        send(1'b0, 8'h5A, ta);
        wait_rx(1'b0, tr);
        check("after_rst_data", a_if.rx_data, 8'h5A);
        check("after_rst_model", (got_q.size() > gbase) ? got_q[gbase] : 8'hxx, 8'h5A);

        // CLK_DIV=1, 0xFF
        base = b_rise_t.size();
        send(1'b1, 8'hFF, ta);
        wait_rx(1'b1, tr);
        check("div1_rxv_cycle", cyc(ta + 5, tr), 16);
        check("div1_rx_data", b_if.rx_data, 8'hFF);
        check("div1_rises", b_rise_t.size() - base, 8);
        if (b_rise_t.size() >= base + 2) begin
            check("div1_first_rise", cyc(ta, b_rise_t[base]), 1);
            check("div1_period", cyc(b_rise_t[base], b_rise_t[base+1]), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
